// File: rtl/monocular_pkg.sv
// Shared record layout and widths for the SignalAnalyser -> FIFO -> DataSender path.
package monocular_pkg;

    localparam int RECORD_WIDTH     = 40;
    localparam int TIME_WIDTH       = 32;
    localparam int PIN_WIDTH        = 8;
    localparam int DROP_COUNT_WIDTH = 8;

    localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX = '1;
    localparam logic [DROP_COUNT_WIDTH-1:0] DROP_ONE =
        {{(DROP_COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [TIME_WIDTH-1:0] stamp;
        logic [PIN_WIDTH-1:0]  pins;
    } record_t;

endpackage

// File: rtl/change_fifo_if.sv
// Write/read/status bundle between the change FIFO and its neighbours.
interface change_fifo_if
    import monocular_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = RECORD_WIDTH
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                        wr_valid;
    logic [WIDTH-1:0]            wr_data;
    logic                        rd_ack;
    logic                        clear_overflow;
    logic                        rd_valid;
    logic [WIDTH-1:0]            rd_data;
    logic [LW-1:0]               level;
    logic                        overflow;
    logic [DROP_COUNT_WIDTH-1:0] dropped;

    modport master (
        output wr_valid, wr_data, rd_ack, clear_overflow,
        input  rd_valid, rd_data, level, overflow, dropped
    );

    modport slave (
        input  wr_valid, wr_data, rd_ack, clear_overflow,
        output rd_valid, rd_data, level, overflow, dropped
    );

endinterface

// File: rtl/change_fifo_record_ram.sv
// Record storage: one synchronous write port, one asynchronous read port.
module record_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 40,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/change_fifo.sv
// First-word fall-through FIFO for pin-change records with sticky drop tracking.
module change_fifo
    import monocular_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = RECORD_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    change_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] STEP = {{AW{1'b0}}, 1'b1};

    // Pointers carry a wrap bit so their difference spans 0..DEPTH.
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] lvl;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;
    logic        overflow_q;
    logic [DROP_COUNT_WIDTH-1:0] dropped_q;
    logic [WIDTH-1:0] head;

    assign lvl   = wptr - rptr;
    assign empty = (lvl == '0);
    assign full  = (lvl == FULL);
    assign pop   = bus.rd_ack && !empty;
    assign push  = bus.wr_valid && (!full || pop);
    assign drop  = bus.wr_valid && full && !bus.rd_ack;

    record_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr[AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (rptr[AW-1:0]),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + STEP;
            if (pop)  rptr <= rptr + STEP;
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (bus.clear_overflow)
                dropped_q <= DROP_ONE;
            else if (dropped_q != DROP_MAX)
                dropped_q <= dropped_q + DROP_ONE;
        end else if (bus.clear_overflow) begin
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end
    end

    assign bus.rd_valid = !empty;
    assign bus.rd_data  = head;
    assign bus.level    = lvl;
    assign bus.overflow = overflow_q;
    assign bus.dropped  = dropped_q;

endmodule

// File: tb/tb_change_fifo.sv
// Directed bench for change_fifo with a queue-based reference model.
module tb_change_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 40;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [WIDTH-1:0] q [$];
    logic             ovf;
    logic [7:0]       drp;

    change_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    change_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: unbounded queue trimmed by the capacity rule.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            ovf <= 1'b0;
            drp <= 8'd0;
        end else begin
            if (bus.wr_valid && q.size() == DEPTH && !bus.rd_ack) begin
                ovf <= 1'b1;
                drp <= bus.clear_overflow ? 8'd1 :
                       (drp == 8'd255 ? drp : drp + 8'd1);
            end else if (bus.clear_overflow) begin
                ovf <= 1'b0;
                drp <= 8'd0;
            end
            if (bus.rd_ack && q.size() > 0) void'(q.pop_front());
            if (bus.wr_valid && q.size() < DEPTH) q.push_back(bus.wr_data);
        end
    end

    always @(negedge clk) begin
        chk("m_rd_valid", 64'(bus.rd_valid), 64'(q.size() != 0));
        chk("m_level", 64'(bus.level), 64'(q.size()));
        if (q.size() != 0) chk("m_rd_data", 64'(bus.rd_data), 64'(q[0]));
        chk("m_overflow", 64'(bus.overflow), 64'(ovf));
        chk("m_dropped", 64'(bus.dropped), 64'(drp));
    end

    task automatic cyc(input logic wv, input logic [WIDTH-1:0] d,
                       input logic ack, input logic clr);
        bus.wr_valid       = wv;
        bus.wr_data        = d;
        bus.rd_ack         = ack;
        bus.clear_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data = '0;
        bus.rd_ack = 1'b0;
        bus.clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 64'(bus.level), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_dropped", 64'(bus.dropped), 64'd0);
        rst = 1'b1;
        cyc(0, '0, 0, 0);

        // single record latency
        cyc(1, 40'h00000001D2, 0, 0);
        chk("first_valid", 64'(bus.rd_valid), 64'd1);
        chk("first_data", 64'(bus.rd_data), 64'h00000001D2);
        chk("first_level", 64'(bus.level), 64'd1);
        cyc(0, '0, 1, 0);
        chk("first_pop", 64'(bus.level), 64'd0);

        // fill then overflow
        for (int i = 0; i < DEPTH; i++)
            cyc(1, {32'(i), 8'(i + 8'h10)}, 0, 0);
        chk("full_level", 64'(bus.level), 64'd16);
        cyc(1, {32'd16, 8'hEE}, 0, 0);
        chk("ovf_flag", 64'(bus.overflow), 64'd1);
        chk("ovf_count", 64'(bus.dropped), 64'd1);
        chk("ovf_head", 64'(bus.rd_data[39:8]), 64'd0);
        chk("ovf_level", 64'(bus.level), 64'd16);

        // full push+pop together
        cyc(1, {32'd100, 8'h55}, 1, 0);
        chk("fpp_level", 64'(bus.level), 64'd16);
        chk("fpp_dropped", 64'(bus.dropped), 64'd1);
        chk("fpp_head", 64'(bus.rd_data[39:8]), 64'd1);
        repeat (15) cyc(0, '0, 1, 0);
        chk("fpp_last", 64'(bus.rd_data[39:8]), 64'd100);
        cyc(0, '0, 1, 0);
        chk("fpp_empty", 64'(bus.level), 64'd0);

        // clear, empty rd_ack, empty push+pop
        cyc(0, '0, 0, 1);
        chk("clr_flag", 64'(bus.overflow), 64'd0);
        chk("clr_count", 64'(bus.dropped), 64'd0);
        repeat (3) cyc(0, '0, 1, 0);
        chk("eack_level", 64'(bus.level), 64'd0);
        chk("eack_valid", 64'(bus.rd_valid), 64'd0);
        cyc(1, {32'd200, 8'h77}, 1, 0);
        chk("epp_level", 64'(bus.level), 64'd1);
        chk("epp_data", 64'(bus.rd_data), 64'h000000C877);

        // saturation and clear-vs-drop
        for (int i = 0; i < DEPTH - 1; i++)
            cyc(1, {32'(300 + i), 8'(i)}, 0, 0);
        for (int i = 0; i < 300; i++)
            cyc(1, {32'hDEAD0000 + 32'(i), 8'hFF}, 0, 0);
        chk("sat_count", 64'(bus.dropped), 64'd255);
        chk("sat_head", 64'(bus.rd_data[39:8]), 64'd200);
        cyc(1, {32'hBEEF, 8'h01}, 0, 1);
        chk("clrdrop_flag", 64'(bus.overflow), 64'd1);
        chk("clrdrop_count", 64'(bus.dropped), 64'd1);
        cyc(0, '0, 0, 1);
        chk("clr2_count", 64'(bus.dropped), 64'd0);

        // asynchronous reset mid-operation
        repeat (11) cyc(0, '0, 1, 0);
        chk("pre_rst_level", 64'(bus.level), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.rd_valid), 64'd0);
        chk("arst_level", 64'(bus.level), 64'd0);
        cyc(0, '0, 0, 0);
        rst = 1'b1;
        cyc(1, {32'd7, 8'hAB}, 0, 0);
        chk("post_rst_pins", 64'(bus.rd_data[7:0]), 64'hAB);
        chk("post_rst_level", 64'(bus.level), 64'd1);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/change_fifo.md
CHANGE_FIFO -- requirements
Module: change_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of 40-bit records held; SHALL be a power of two, >= 2.
REQ-002 Parameter WIDTH, default 40, record width = {time[31:0], pins[7:0]}.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset); release SHALL be synchronous to clk.
REQ-005 wr_valid  input  1  upstream SignalAnalyser offers a record this cycle.
REQ-006 wr_data  input  WIDTH  record offered; bits [39:8] time, bits [7:0] pin values.
REQ-007 rd_ack  input  1  DataSender has consumed the head record (one-cycle pulse).
REQ-008 clear_overflow  input  1  clears overflow and dropped.
REQ-009 rd_valid  output  1  FIFO non-empty; rd_data holds the head record.
REQ-010 rd_data  output  WIDTH  head record (first-word fall-through).
REQ-011 level  output  log2(DEPTH)+1  records currently stored, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag: at least one record dropped since last clear.
REQ-013 dropped  output  8  count of dropped records, saturating at 255.

Function
REQ-014 Push SHALL occur when wr_valid=1 and (level<DEPTH or rd_ack=1 with level>0); the record is written at the write pointer, which SHALL advance modulo DEPTH.
REQ-015 Pop SHALL occur when rd_ack=1 and level>0; the read pointer SHALL advance modulo DEPTH; rd_ack with level=0 SHALL be ignored.
REQ-016 level SHALL change by +1 (push only), -1 (pop only), 0 (both or neither) per cycle.
REQ-017 Full with push and pop in the same cycle: both SHALL take effect, level stays DEPTH, no drop.
REQ-018 Empty with push and pop in the same cycle: pop ignored, push accepted, level becomes 1.
REQ-019 Latency: a record pushed into an empty FIFO at edge N SHALL appear on rd_data with rd_valid=1 after edge N; no combinational wr_data->rd_data bypass.
REQ-020 rd_data SHALL be stable while rd_valid=1 and no pop occurs; it is don't-care when rd_valid=0.
REQ-021 Drop: wr_valid=1, level=DEPTH, rd_ack=0 SHALL discard the record, set overflow=1, increment dropped unless already 255; storage and pointers unchanged.
REQ-022 clear_overflow=1 SHALL set overflow=0, dropped=0 at the next edge; a drop in the same cycle SHALL win: overflow=1, dropped=1.
REQ-023 Records SHALL emerge in push order with no duplication or loss other than REQ-021 drops.

Reset
REQ-024 While rst=0: pointers=0, level=0, rd_valid=0, overflow=0, dropped=0; storage contents unspecified and not reset.
REQ-025 Reset asserted mid-operation SHALL discard all stored records immediately; the first cycle after release SHALL accept a push.

Structure
REQ-026 RECORD_WIDTH=40, TIME_WIDTH=32, PIN_WIDTH=8 and DROP_COUNT_WIDTH=8 SHALL live in shared package monocular_pkg, also used by SignalAnalyser and DataSender.
REQ-027 Storage SHALL be one sub-module record_ram (DEPTH x WIDTH, one synchronous write port, one asynchronous read port); pointer/level/overflow control stays in change_fifo.
REQ-028 Pointers SHALL be log2(DEPTH)+1 bits wide (wrap bit) or level-tracked; full/empty SHALL not depend on pointer equality alone.

Verification
REQ-029 Reset, push 0x00000001_D2 -> next cycle rd_valid=1, rd_data=0x00000001D2, level=1.
REQ-030 Push 16 records time=0..15, no rd_ack -> level=16; 17th push -> overflow=1, dropped=1, rd_data time=0 unchanged.
REQ-031 Full, wr_valid and rd_ack together -> level stays 16, no drop, head advances to time=1, new record last out.
REQ-032 Empty, rd_ack alone for 3 cycles -> level=0, rd_valid=0, no pointer movement; then push/pop same cycle -> level=1.
REQ-033 300 drops while full -> dropped=255 saturated; clear_overflow with a simultaneous drop -> overflow=1, dropped=1.
REQ-034 rst=0 asserted between edges with level=5 -> rd_valid=0, level=0 immediately; after release, push 0xAB -> rd_data[7:0]=0xAB next cycle.
